// File: rtl/parking_input_conditioner_pkg.sv
// parking_input_conditioner_pkg: shared defaults and raw idle levels for the input conditioner
package parking_input_conditioner_pkg;
   localparam int   DEBOUNCE_DEFAULT = 500000;
   localparam int   TOKEN_W_DEFAULT  = 5;
   localparam logic RAW_IDLE_SENSOR  = 1'b0;
   localparam logic RAW_IDLE_TOKEN   = 1'b0;
   // An active-low button idles high on the raw pin.
   function automatic logic btn_raw_idle(input logic active_low);
      return active_low;
   endfunction
endpackage

// File: rtl/parking_input_conditioner_debounce_channel.sv
// debounce_channel: 2-flop sync, debounce counter and stable register for one W-bit channel
//   clk, reset : clock, asynchronous active-high reset
//   raw        : raw input bits, asynchronous to clk
//   stable     : debounced value, the whole bus is replaced in one cycle
module debounce_channel
   import parking_input_conditioner_pkg::*;
#(
   parameter int   W               = 1,
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter logic RST_LEVEL       = 1'b0
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] raw,
   output logic [W-1:0] stable
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [W-1:0]  meta_q, meta_d, sync_q, sync_d, prev_q, prev_d, stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mismatch, changed, accept;
   always_comb begin
      meta_d   = raw;
      sync_d   = meta_q;
      prev_d   = sync_q;
      mismatch = sync_q != stable_q;
      // A new value on the bus restarts the count with this sample as the first one.
      changed  = sync_q != prev_q;
      accept   = mismatch && !changed && cnt_q == LAST;
      cnt_d    = !mismatch ? '0 : changed ? CW'(1) : accept ? '0 : cnt_q + 1'b1;
      stable_d = accept ? sync_q : stable_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q   <= {W{RST_LEVEL}};
         sync_q   <= {W{RST_LEVEL}};
         prev_q   <= {W{RST_LEVEL}};
         stable_q <= {W{RST_LEVEL}};
         cnt_q    <= '0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
   assign stable = stable_q;
endmodule

// File: rtl/parking_input_conditioner.sv
// parking_input_conditioner: synchronise, debounce and shape board inputs for parking_fsm
//   clk, reset                       : clock, asynchronous active-high reset
//   entry/exit_btn_raw               : raw push-buttons (polarity set by BTN_ACTIVE_LOW)
//   entry/exit_sensor_raw, token_raw : raw active-high switches
//   entry/exit_btn                   : one-clk pulse per debounced press
//   entry/exit_sensor, token_out     : debounced levels
module parking_input_conditioner
   import parking_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int BTN_ACTIVE_LOW  = 1,
   parameter int TOKEN_W         = TOKEN_W_DEFAULT
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               entry_btn_raw,
   input  logic               exit_btn_raw,
   input  logic               entry_sensor_raw,
   input  logic               exit_sensor_raw,
   input  logic [TOKEN_W-1:0] token_raw,
   output logic               entry_btn,
   output logic               exit_btn,
   output logic               entry_sensor,
   output logic               exit_sensor,
   output logic [TOKEN_W-1:0] token_out
);
   localparam logic BTN_IDLE = btn_raw_idle(BTN_ACTIVE_LOW != 0);
   logic [1:0] btn_stable, btn_level, btn_prev_q, btn_prev_d, btn_pulse_q, btn_pulse_d;
   debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(BTN_IDLE)) u_entry_btn (
      .clk(clk), .reset(reset), .raw(entry_btn_raw), .stable(btn_stable[0]));
   debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(BTN_IDLE)) u_exit_btn (
      .clk(clk), .reset(reset), .raw(exit_btn_raw), .stable(btn_stable[1]));
   debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(RAW_IDLE_SENSOR)) u_entry_sensor (
      .clk(clk), .reset(reset), .raw(entry_sensor_raw), .stable(entry_sensor));
   debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(RAW_IDLE_SENSOR)) u_exit_sensor (
      .clk(clk), .reset(reset), .raw(exit_sensor_raw), .stable(exit_sensor));
   debounce_channel #(.W(TOKEN_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(RAW_IDLE_TOKEN)) u_token (
      .clk(clk), .reset(reset), .raw(token_raw), .stable(token_out));
   always_comb begin
      // Stable levels are kept in raw polarity; pressed becomes 1 here.
      btn_level   = btn_stable ^ {2{BTN_IDLE}};
      btn_prev_d  = btn_level;
      btn_pulse_d = btn_level & ~btn_prev_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev_q  <= '0;
         btn_pulse_q <= '0;
      end else begin
         btn_prev_q  <= btn_prev_d;
         btn_pulse_q <= btn_pulse_d;
      end
   end
   assign entry_btn = btn_pulse_q[0];
   assign exit_btn  = btn_pulse_q[1];
endmodule

// File: tb/tb_parking_input_conditioner.sv
// tb_parking_input_conditioner: table, directed and randomized checks of the input conditioner
module tb_parking_input_conditioner;
   localparam int D  = 4;
   localparam int TW = 5;
   typedef struct {int ch; int len; int on; int off; int hi;} vec_t;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          entry_btn_raw = 1'b1;
   logic          exit_btn_raw = 1'b1;
   logic          entry_sensor_raw = 1'b0;
   logic          exit_sensor_raw = 1'b0;
   logic [TW-1:0] token_raw = '0;
   logic          entry_btn, exit_btn, entry_sensor, exit_sensor;
   logic [TW-1:0] token_out;
   int            total = 0;
   int            bad = 0;
   vec_t          vt [10];
   logic [4:0]    samp [5][64];
   logic [4:0]    stab [5];
   logic [4:0]    idle [5];
   logic          lvl1 [2];
   logic          lvl2 [2];
   logic          exp_p [2];
   int            n;

   always #5 clk = ~clk;

   parking_input_conditioner #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1), .TOKEN_W(TW)) dut (
      .clk(clk), .reset(reset),
      .entry_btn_raw(entry_btn_raw), .exit_btn_raw(exit_btn_raw),
      .entry_sensor_raw(entry_sensor_raw), .exit_sensor_raw(exit_sensor_raw),
      .token_raw(token_raw),
      .entry_btn(entry_btn), .exit_btn(exit_btn),
      .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
      .token_out(token_out));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic out_of(input int ch);
      return ch == 0 ? entry_sensor : ch == 1 ? exit_sensor : ch == 2 ? entry_btn : exit_btn;
   endfunction

   task automatic drive(input int ch, input logic act);
      if (ch == 0) entry_sensor_raw = act;
      else if (ch == 1) exit_sensor_raw = act;
      else if (ch == 2) entry_btn_raw = ~act;
      else exit_btn_raw = ~act;
   endtask

   // Reference: a channel takes value v once the last D synchronised samples
   // (raw delayed by 2 clk) all equal v and v differs from the current level.
   function automatic logic [4:0] val(input int c, input int k);
      return k < 0 ? idle[c] : samp[c][k & 63];
   endfunction

   task automatic model_reset();
      n = 0;
      for (int c = 0; c < 5; c++) stab[c] = idle[c];
      for (int b = 0; b < 2; b++) begin
         lvl1[b] = 1'b0;
         lvl2[b] = 1'b0;
         exp_p[b] = 1'b0;
      end
   endtask

   task automatic model_step();
      logic [4:0] rawv [5];
      logic [4:0] v;
      logic       same;
      rawv[0] = {4'b0, entry_btn_raw};
      rawv[1] = {4'b0, exit_btn_raw};
      rawv[2] = {4'b0, entry_sensor_raw};
      rawv[3] = {4'b0, exit_sensor_raw};
      rawv[4] = token_raw;
      for (int c = 0; c < 5; c++) begin
         samp[c][n & 63] = rawv[c];
         v = val(c, n - 2);
         same = 1'b1;
         for (int j = 1; j < D; j++) if (val(c, n - 2 - j) != v) same = 1'b0;
         if (same && v != stab[c]) stab[c] = v;
      end
      for (int b = 0; b < 2; b++) begin
         exp_p[b] = lvl1[b] & ~lvl2[b];
         lvl2[b] = lvl1[b];
         lvl1[b] = stab[b] != idle[b];
      end
      n++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      int on, off, hi, land, mixed, pe, px, ae, ax;
      logic [4:0] tseq [4];
      int left [5];
      idle[0] = 5'd1; idle[1] = 5'd1; idle[2] = 5'd0; idle[3] = 5'd0; idle[4] = 5'd0;
      // {channel, active length, first high cycle, first low cycle after that, high cycles}
      vt[0] = '{0, 1, -1, -1, 0};
      vt[1] = '{0, 2, -1, -1, 0};
      vt[2] = '{0, 3, -1, -1, 0};
      vt[3] = '{0, 10, 6, 16, 10};
      vt[4] = '{0, 4, 6, 10, 4};
      vt[5] = '{1, 5, 6, 11, 5};
      vt[6] = '{2, 20, 7, 8, 1};
      vt[7] = '{2, 3, -1, -1, 0};
      vt[8] = '{2, 20, 7, 8, 1};
      vt[9] = '{3, 4, 7, 8, 1};
      #2 check("reset_state", {entry_btn, exit_btn, entry_sensor, exit_sensor, token_out}, 0);
      repeat (3) tick();
      reset = 1'b0;
      pe = 0;
      repeat (20) begin
         tick();
         if (entry_btn !== 1'b0 || exit_btn !== 1'b0) pe++;
      end
      check("idle_no_pulse", pe, 0);
      entry_sensor_raw = 1'b1; exit_sensor_raw = 1'b1; token_raw = '1;
      repeat (10) tick();
      check("pre_reset_levels", {entry_sensor, exit_sensor, token_out}, 7'h7f);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 check("async_reset", {entry_btn, exit_btn, entry_sensor, exit_sensor, token_out}, 0);
      @(negedge clk);
      entry_sensor_raw = 1'b0; exit_sensor_raw = 1'b0; token_raw = '0;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      for (int k = 0; k < 10; k++) begin
         on = -1; off = -1; hi = 0;
         drive(vt[k].ch, 1'b1);
         for (int i = 1; i <= vt[k].len + 20; i++) begin
            tick();
            if (i == vt[k].len) drive(vt[k].ch, 1'b0);
            if (out_of(vt[k].ch) === 1'b1) begin
               hi++;
               if (on < 0) on = i;
            end else if (on >= 0 && off < 0) off = i;
         end
         check($sformatf("vec%0d_on", k), on, vt[k].on);
         check($sformatf("vec%0d_off", k), off, vt[k].off);
         check($sformatf("vec%0d_high", k), hi, vt[k].hi);
      end
      tseq[0] = 5'b10110; tseq[1] = 5'b10100; tseq[2] = 5'b10110; tseq[3] = 5'b10100;
      land = -1; mixed = 0;
      for (int i = 1; i <= 25; i++) begin
         token_raw = i <= 4 ? tseq[i-1] : 5'b10110;
         tick();
         if (token_out !== 5'b00000 && token_out !== 5'b10110) mixed++;
         if (land < 0 && token_out === 5'b10110) land = i;
      end
      check("token_mixed", mixed, 0);
      check("token_land", land, 10);
      token_raw = '0;
      repeat (12) tick();
      check("token_back", token_out, 0);
      entry_btn_raw = 1'b0; exit_btn_raw = 1'b0;
      pe = 0; px = 0; ae = -1; ax = -1;
      for (int i = 1; i <= 30; i++) begin
         if (i == 13) begin
            entry_btn_raw = 1'b1; exit_btn_raw = 1'b1;
         end
         tick();
         if (entry_btn === 1'b1) begin pe++; ae = i; end
         if (exit_btn === 1'b1) begin px++; ax = i; end
      end
      check("both_entry_count", pe, 1);
      check("both_exit_count", px, 1);
      check("both_entry_at", ae, 7);
      check("both_exit_at", ax, 7);
      entry_btn_raw = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      pe = 0; ae = -1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 13) entry_btn_raw = 1'b1;
         tick();
         if (entry_btn === 1'b1) begin
            pe++;
            if (ae < 0) ae = i;
         end
      end
      check("held_reset_count", pe, 1);
      check("held_reset_at", ae, 7);
      repeat (10) tick();
      exit_btn_raw = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      exit_btn_raw = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      pe = 0;
      repeat (20) begin
         tick();
         if (entry_btn !== 1'b0 || exit_btn !== 1'b0) pe++;
      end
      check("lost_count_no_pulse", pe, 0);
      reset = 1'b1;
      model_reset();
      for (int c = 0; c < 5; c++) left[c] = 0;
      tick();
      for (int cyc = 0; cyc < 800; cyc++) begin
         reset = cyc > 0 && $urandom_range(0, 99) == 0;
         for (int c = 0; c < 5; c++) begin
            if (left[c] == 0) begin
               if (c == 0) entry_btn_raw = 1'($urandom_range(0, 1));
               else if (c == 1) exit_btn_raw = 1'($urandom_range(0, 1));
               else if (c == 2) entry_sensor_raw = 1'($urandom_range(0, 1));
               else if (c == 3) exit_sensor_raw = 1'($urandom_range(0, 1));
               else token_raw = 5'($urandom_range(0, 31));
               left[c] = $urandom_range(1, 7);
            end
            left[c]--;
         end
         @(posedge clk);
         if (reset) model_reset();
         else model_step();
         @(negedge clk);
         check($sformatf("rnd%0d_entry_btn", cyc), entry_btn, exp_p[0]);
         check($sformatf("rnd%0d_exit_btn", cyc), exit_btn, exp_p[1]);
         check($sformatf("rnd%0d_entry_sensor", cyc), entry_sensor, stab[2][0]);
         check($sformatf("rnd%0d_exit_sensor", cyc), exit_sensor, stab[3][0]);
         check($sformatf("rnd%0d_token", cyc), token_out, stab[4]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
